// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
//
// Multi-channel clock-enable / square-wave generator running from the 50 MHz
// board clock. Each of the NCH channels counts clk_50mhz cycles against a
// programmable half-period H and toggles its square-wave output at every
// terminal count. A one-cycle tick accompanies each rising edge of the square
// wave, so downstream logic can use tick as a clock enable.
//
// Parameters
//   NCH        number of channels (1..16)
//   CW         counter / half-period width
//   HALF_INIT  packed NCH*CW reset half-periods, channel i at [i*CW +: CW]
//
// Ports
//   clk_50mhz  in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   en         in   [NCH] per-channel run enable
//   div_ld     in   single-cycle strobe: pend[div_sel] <= div_val
//   div_sel    in   [4]   target channel for div_ld (>= NCH is ignored)
//   div_val    in   [CW]  new half-period in clk_50mhz cycles (0 acts as 1)
//   sync       in   single-cycle strobe: restart every channel phase-aligned
//   clk_out    out  [NCH] registered 50 % square waves
//   tick       out  [NCH] registered pulse in the cycle clk_out becomes 1
//
// Strobe semantics: div_ld and sync carry no handshake. They are sampled on
// every rising clk_50mhz edge and act exactly once for each cycle they are
// high; there is no back-pressure and no acknowledgement.
// -----------------------------------------------------------------------------
module clk_div_bank #(
  parameter int unsigned            NCH       = 4,
  parameter int unsigned            CW        = 32,
  parameter logic [NCH*CW-1:0]      HALF_INIT = {32'd25_000, 32'd500_000,
                                                 32'd12_500_000, 32'd25_000_000}
) (
  input  logic           clk_50mhz,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           div_ld,
  input  logic [3:0]     div_sel,
  input  logic [CW-1:0]  div_val,
  input  logic           sync,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic [CW-1:0] act;
    logic [CW-1:0] pend;
    logic          out_q;
    logic          tick_q;
    logic          ld_hit;
    logic [CW-1:0] term_val;
    logic          term;

    // Indices >= NCH never match any channel, so out-of-range loads fall away.
    assign ld_hit = div_ld && (div_sel == 4'(i));

    // Terminal count is H-1 with H = max(act, 1); act == 0 behaves as H = 1.
    assign term_val = (act == '0) ? '0 : act - CW'(1);

    // act only changes when cnt is forced to 0, so cnt never exceeds
    // term_val; the >= merely keeps the counter bounded if it ever did.
    assign term = (cnt >= term_val);

    always_ff @(posedge clk_50mhz or negedge rst) begin
      if (!rst) begin
        cnt    <= '0;
        act    <= HALF_INIT[i*CW +: CW];
        pend   <= HALF_INIT[i*CW +: CW];
        out_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        if (ld_hit) begin
          pend <= div_val;
        end

        if (sync) begin
          // A load in the same cycle as sync bypasses pend so the restart
          // already runs at the new ratio.
          cnt    <= '0;
          out_q  <= 1'b0;
          tick_q <= 1'b0;
          act    <= ld_hit ? div_val : pend;
        end else if (!en[i]) begin
          cnt    <= '0;
          out_q  <= 1'b0;
          tick_q <= 1'b0;
        end else if (term) begin
          // Ratio changes are applied only here, at a half-period boundary,
          // so no half-period is ever cut short. A load arriving in this same
          // cycle lands in pend and waits for the following boundary.
          cnt    <= '0;
          out_q  <= ~out_q;
          tick_q <= ~out_q;
          act    <= pend;
        end else begin
          cnt    <= cnt + CW'(1);
          tick_q <= 1'b0;
        end
      end
    end

    assign clk_out[i] = out_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_div_bank
//
// Bench for clk_div_bank with NCH=4, CW=8, HALF_INIT={4,3,2,1}. The driver
// pushes the hand-computed edge number of every expected clk_out transition
// into a per-channel queue; the monitor pops an entry whenever an armed
// channel's clk_out changes and also checks that tick matches each rise.
// Edge numbering: cyc counts rising clk_50mhz edges; inputs are driven at the
// falling edge, so an input set while cyc == c is first sampled at edge c+1.
// -----------------------------------------------------------------------------
module tb_clk_div_bank;
  localparam int NCH = 4;
  localparam int CW  = 8;

  logic           clk_50mhz = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic           div_ld;
  logic [3:0]     div_sel;
  logic [CW-1:0]  div_val;
  logic           sync;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  clk_div_bank #(
    .NCH       (NCH),
    .CW        (CW),
    .HALF_INIT ({8'd4, 8'd3, 8'd2, 8'd1})
  ) dut (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .en        (en),
    .div_ld    (div_ld),
    .div_sel   (div_sel),
    .div_val   (div_val),
    .sync      (sync),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  // ---------------- clock / cycle counter ----------------
  always #10 clk_50mhz = ~clk_50mhz;

  int unsigned cyc = 0;
  always @(posedge clk_50mhz) cyc <= cyc + 1;

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0]    exp_q [NCH][$];
  logic [NCH-1:0] armed    = '0;
  logic [NCH-1:0] prev_out = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Expected transitions every h edges after edge 'start', up to 'last'.
  task automatic push_train(input int ch, input int unsigned start,
                            input int unsigned h, input int unsigned last);
    for (int unsigned t = start + h; t <= last; t += h) exp_q[ch].push_back(t);
  endtask

  task automatic end_window(input logic [NCH-1:0] m);
    for (int ch = 0; ch < NCH; ch++) begin
      if (m[ch]) begin
        check($sformatf("missing edges ch%0d", ch), exp_q[ch].size(), 0);
        exp_q[ch].delete();
      end
    end
    armed = '0;
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  always @(posedge clk_50mhz) begin
    logic [31:0] t;
    logic        rise;
    #1;
    for (int ch = 0; ch < NCH; ch++) begin
      if (armed[ch]) begin
        rise = clk_out[ch] && !prev_out[ch];
        if (clk_out[ch] != prev_out[ch]) begin
          checks++;
          if (exp_q[ch].size() == 0) begin
            errors++;
            $display("FAIL edge ch%0d: transition at cycle %0d, required none", ch, cyc);
          end else begin
            t = exp_q[ch].pop_front();
            if (t != cyc) begin
              errors++;
              $display("FAIL edge ch%0d: transition at cycle %0d, required cycle %0d", ch, cyc, t);
            end
          end
        end
        if (tick[ch] || rise) begin
          checks++;
          if (tick[ch] != rise) begin
            errors++;
            $display("FAIL tick ch%0d: tick=%0b at cycle %0d, required %0b (clk_out rise)",
                     ch, tick[ch], cyc, rise);
          end
        end
      end
    end
    prev_out = clk_out;
  end

  // ---------------- driver tasks ----------------
  task automatic load(input logic [3:0] sel, input logic [CW-1:0] val);
    div_ld  = 1'b1;
    div_sel = sel;
    div_val = val;
    @(negedge clk_50mhz);
    div_ld  = 1'b0;
  endtask

  task automatic do_sync(input logic ld, input logic [3:0] sel, input logic [CW-1:0] val,
                         output int unsigned s);
    sync    = 1'b1;
    div_ld  = ld;
    div_sel = sel;
    div_val = val;
    @(negedge clk_50mhz);
    sync    = 1'b0;
    div_ld  = 1'b0;
    s       = cyc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned s;
    int unsigned c0;
    logic        found;

    rst = 1'b0; en = '0; div_ld = 1'b0; div_sel = '0; div_val = '0; sync = 1'b0;
    repeat (3) @(negedge clk_50mhz);
    check("reset clk_out", clk_out, 0);
    check("reset tick", tick, 0);

    // Reset defaults: H = 1,2,3,4 on ch0..3 -> periods 2,4,6,8.
    en = '1;
    c0 = cyc;
    for (int ch = 0; ch < NCH; ch++) push_train(ch, c0, ch + 1, c0 + 24);
    armed = '1;
    rst   = 1'b1;
    repeat (24) @(negedge clk_50mhz);
    end_window('1);

    // sync + load ch0=5 together, then glitch-free load of 2 at cnt=1:
    // first half-period still 5, then every half-period 2.
    do_sync(1'b1, 4'd0, 8'd5, s);
    armed = 4'b0001;
    exp_q[0].push_back(s + 5);
    for (int unsigned t = s + 7; t <= s + 21; t += 2) exp_q[0].push_back(t);
    @(negedge clk_50mhz);
    load(4'd0, 8'd2);
    repeat (19) @(negedge clk_50mhz);
    end_window(4'b0001);

    // Sync alignment with H = 3,5,7 on ch0..2.
    load(4'd0, 8'd3);
    load(4'd1, 8'd5);
    load(4'd2, 8'd7);
    repeat (2) @(negedge clk_50mhz);
    do_sync(1'b0, 4'd0, 8'd0, s);
    check("sync clears clk_out", clk_out, 0);
    push_train(0, s, 3, s + 35);
    push_train(1, s, 5, s + 35);
    push_train(2, s, 7, s + 35);
    armed = 4'b0111;
    repeat (35) @(negedge clk_50mhz);
    end_window(4'b0111);

    // ch1 rose at edge s+35 and is high until s+40: disable it mid-high.
    @(negedge clk_50mhz);
    check("ch1 high before disable", clk_out[1], 1);
    en[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_50mhz);
      check("disabled clk_out[1]", clk_out[1], 0);
      check("disabled tick[1]", tick[1], 0);
    end
    en[1] = 1'b1;
    c0    = cyc;
    push_train(1, c0, 5, c0 + 30);
    armed = 4'b0010;
    repeat (30) @(negedge clk_50mhz);
    end_window(4'b0010);

    // div_val = 0 behaves as H = 1: clk/2 toggle.
    load(4'd3, 8'd0);
    do_sync(1'b0, 4'd0, 8'd0, s);
    push_train(3, s, 1, s + 12);
    armed = 4'b1000;
    repeat (12) @(negedge clk_50mhz);
    end_window(4'b1000);

    // div_sel = 4 is out of range: ch0 keeps H=3, ch2 keeps H=7.
    load(4'd4, 8'd9);
    do_sync(1'b0, 4'd0, 8'd0, s);
    push_train(0, s, 3, s + 21);
    push_train(2, s, 7, s + 21);
    armed = 4'b0101;
    repeat (21) @(negedge clk_50mhz);
    end_window(4'b0101);

    // Reset mid-count while ch3 (H=1) is high: outputs drop without a clock.
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found) begin
        @(negedge clk_50mhz);
        if (clk_out[3]) found = 1'b1;
      end
    end
    check("ch3 high before reset", found, 1);
    #3 rst = 1'b0;
    #1;
    check("async reset clk_out", clk_out, 0);
    check("async reset tick", tick, 0);
    @(negedge clk_50mhz);
    c0 = cyc;
    for (int ch = 0; ch < NCH; ch++) push_train(ch, c0, ch + 1, c0 + 12);
    armed = '1;
    rst   = 1'b1;
    repeat (12) @(negedge clk_50mhz);
    end_window('1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised multi-channel clock-enable and square-wave generator for the 50 MHz board clock. Replaces fixed per-rate dividers with NCH independent channels, each with a runtime-programmable half-period, per-channel enable, glitch-free ratio update and a global phase-align restart. Each channel outputs a 50 % square wave and a one-cycle tick for use as a clock enable by downstream counters, scanners and debouncers.

## Interface

- NCH, 4, number of divider channels (1..16).
- CW, 32, counter and half-period width in bits.
- HALF_INIT, {32'd25_000, 32'd500_000, 32'd12_500_000, 32'd25_000_000}, packed NCH*CW reset half-periods; channel i is bits [i*CW +: CW]. The defaults give 1 Hz, 2 Hz, 50 Hz and 1 kHz on channels 0..3.

- clk_50mhz  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  NCH  per-channel run enable.
- div_ld  in  1  single-cycle strobe that loads div_val into channel div_sel.
- div_sel  in  4  target channel index for div_ld.
- div_val  in  CW  new half-period, in clk_50mhz cycles.
- sync  in  1  single-cycle strobe that restarts all channels phase-aligned.
- clk_out  out  NCH  registered square-wave outputs.
- tick  out  NCH  registered one-cycle pulse coincident with each clk_out rising edge.

## Operation

- Per-channel state:
  - cnt[CW]: half-period counter.
  - act[CW]: active half-period.
  - pend[CW]: pending half-period.
  - out bit.
- Effective half-period is H = max(act, 1); div_val = 0 is treated as 1. With H = 1 the output is clk_50mhz/2 and tick is high every second cycle.
- Running (en[i]=1):
  - When cnt < H-1: cnt increments.
  - When cnt == H-1 (terminal count): cnt <= 0, out toggles, act <= pend.
  - tick[i] is 1 for exactly the cycle in which out becomes 1.
- Disabled (en[i]=0):
  - cnt <= 0, out <= 0, tick <= 0. act and pend are retained.
  - After en rises, the first rising edge of clk_out comes H cycles later.
- Ratio load: div_ld=1 with div_sel < NCH writes pend[div_sel] <= div_val.
  - act is updated only at that channel's next terminal count, so no half-period is ever truncated or stretched beyond max(old, new).
  - div_sel >= NCH: the load is ignored.
  - A second load before the terminal count overwrites pend; only the last value is applied.
- sync=1, applied to all channels regardless of en:
  - cnt <= 0, out <= 0, tick <= 0, act <= pend.
  - Enabled channels then produce their first rising edge exactly H cycles after sync, so all channels are phase-aligned.
- sync and div_ld in the same cycle: div_val is written to both pend and act of the selected channel, and it takes effect immediately from the restart.
- Priority for each channel: rst > sync > en=0 > normal counting.
- Output period is 2*H cycles with an exact 50 % duty cycle.

## Timing

- Reset (asynchronous assert, synchronous release at the next clk_50mhz edge):
  - cnt = 0, clk_out = 0, tick = 0.
  - act = pend = HALF_INIT.
- Reset asserted mid-operation: all outputs go to 0 immediately, with no clock required. Programmed ratios are lost and revert to HALF_INIT.
- clk_out and tick are registered outputs with no combinational path from inputs.
  - en, sync and div_ld affect the outputs on the clock edge after sampling, i.e. one cycle of latency.
- On the first edge after reset release with en[i]=1, cnt becomes 1. The first clk_out rise happens at edge H. Subsequent edges are every H cycles.
- The counter never wraps past H-1, and act is never compared while being updated.
- Any CW-bit value is a legal half-period.

## Test plan

- **Reset defaults.** Use HALF_INIT={4,3,2,1} (CW=8) with en=4'hF after release. Required: clk_out periods of 2, 4, 6 and 8 cycles. Each tick is high for 1 cycle, coincident with the clk_out rise. All outputs are 0 during reset.
- **Glitch-free load.** Run ch0 with H=5. Pulse div_ld with div_sel=0, div_val=2 at cnt=1. Required: the current half-period completes at 5 cycles, then all following half-periods are 2 cycles. No pulse shorter than 2 cycles appears.
- **Sync alignment.** Run channels with H=3, 5 and 7 and pulse sync at an arbitrary cycle. Required: all clk_out go to 0 on the next edge. Rises occur exactly 3, 5 and 7 cycles after sync.
- **Enable and zero.** Drop en[1] mid-high phase, then raise it 10 cycles later. Required: clk_out[1]=0 and tick[1]=0 while disabled, with the first rise H cycles after en rises. Separately, load div_val=0 and require the clk/2 toggle.
- **Edge cases.** div_ld with div_sel=4 (NCH=4) changes nothing. sync with div_ld in the same cycle applies the new H from the restart. Asserting rst mid-count returns outputs to 0 asynchronously and restores HALF_INIT.
